tdr_bank: RTL and testbench
===========================

# tdr_bank

Parametrised bank of JTAG test data registers sharing one serial shift path, selected by instruction code from the TAP decoder. Captures per-channel status words, shifts LSB-first between SI and SO, and on UpdateDR transfers the shift contents into the selected channel's parallel register. A valid/ack handshake with overrun detection carries each update to the BIST logic. Sits between the TAP controller/IR decoder and the BIST gasket, replacing single-address, fixed-width TDRs.

## Interface
- WIDTH, 17: bits per data register (≥2).
- NUM_TDR, 4: number of channels.
- IR_W, 8: instruction register width.
- BASE_ADDR, 45: instruction code of channel 0; channel i is BASE_ADDR+i.
- RESET_VAL, 0: reset value of every parallel register (WIDTH bits).
---
- TCLK  in  1  test clock; all state updates on rising edge.
- TRESET  in  1  reset, asynchronous, active-high.
- CaptureDR, ShiftDR, UpdateDR  in  1 each  TAP state strobes.
- IR  in  IR_W  current instruction code.
- SI  in  1  serial input.
- SO  out  1  serial output.
- Selected  out  1  IR addresses a channel of this bank.
- CaptureData  in  NUM_TDR*WIDTH  status word per channel; channel i at [i*WIDTH +: WIDTH].
- UpdateData  out  NUM_TDR*WIDTH  parallel registers, same packing.
- UpdateValid  out  NUM_TDR  new parallel data pending per channel.
- UpdateAck  in  NUM_TDR  consumer acknowledge per channel.
- Overrun  out  NUM_TDR  sticky: update arrived while previous one still pending.

## Operation
- Decode: Selected = (IR ≥ BASE_ADDR) && (IR < BASE_ADDR+NUM_TDR); sel = IR − BASE_ADDR (log2 NUM_TDR bits). All strobes ignored when Selected=0.
- One shared WIDTH-bit shift register sr. Priority when Selected: ShiftDR > CaptureDR > hold.
  - ShiftDR: sr <= {SI, sr[WIDTH-1:1]} (LSB exits first).
  - CaptureDR: sr <= CaptureData[sel].
- SO = sr[0] when Selected, else 0. Combinational from sr.
- UpdateDR (Selected): par[sel] <= sr (value before same-edge shift/capture). Other channels unchanged.
- Per-channel handshake (channel i, upd_i = UpdateDR && Selected && sel==i):
  - upd_i: UpdateValid[i] <= 1.
  - else if UpdateAck[i] && UpdateValid[i]: UpdateValid[i] <= 0.
  - upd_i && UpdateValid[i] && !UpdateAck[i]: Overrun[i] <= 1; data still overwritten.
  - upd_i with UpdateAck[i] same edge: valid stays 1, no overrun.
  - UpdateAck[i] while UpdateValid[i]=0: ignored.
- Overrun[i] cleared by CaptureDR with sel==i (and not ShiftDR); set wins if both in one cycle.
- IR change between strobes: sr contents retained; next capture/shift uses new channel.

## Timing
- Reset (TRESET=1, async): sr=0, every par=RESET_VAL, UpdateValid=0, Overrun=0; SO=0.
- Capture → SO: SO shows CaptureData[sel][0] the cycle after the CaptureDR edge.
- Shift of WIDTH cycles fully replaces sr; bit k of SI stream lands in sr[k].
- Update: UpdateData and UpdateValid change on the same edge; ack clears valid on the next edge, i.e. 1-cycle minimum valid pulse.
- Reset mid-shift or mid-handshake: all state returns to reset values immediately; no pending update survives.

## Structure
- Package tdr_pkg: channel-index width function (clog2), in-range decode function, packing helper for the flattened buses.
- Sub-module tdr_channel (parallel register + valid/ack/overrun logic), instantiated NUM_TDR times via generate; decode and sr in top.

## Test plan
- Reset: assert TRESET mid-shift with RESET_VAL=17'h1_5A5A → UpdateData all channels 17'h1_5A5A, UpdateValid=0, Overrun=0, SO=0 without a clock edge.
- Capture/shift: IR=46, CaptureData[1]=17'h0_00CF, CaptureDR then 17 ShiftDR with SI=0 → SO sequence 1,1,1,1,0,0,1,1,0…0 (LSB first), sr ends 0.
- Update: IR=47, shift in 17'h1_2345, UpdateDR → UpdateData[2]=17'h1_2345, UpdateValid=4'b0100 next edge; other channels unchanged; ack → valid clears one edge later.
- Overrun: two updates to channel 0 with no ack → Overrun[0]=1, UpdateData[0]=second value; CaptureDR on IR=45 → Overrun[0]=0.
- Ack/update collision: UpdateAck[3] on same edge as second UpdateDR to IR=48 → UpdateValid[3] stays 1, Overrun[3]=0.
- Out of range: IR=44 and IR=49 with all strobes → Selected=0, SO=0, sr/par/valid unchanged.

Source files
------------

// File: rtl/tdr_pkg.sv
// tdr_pkg: shared helpers for the test data register bank.
//   chanIdxW : width of a channel index for a bank of n channels (min 1)
//   inRange  : instruction-code window decode
//   laneLsb  : LSB position of lane idx in a flattened NUM_TDR*WIDTH bus
//   chanCtrl_t : per-channel control strobes driven by the bank decoder
package tdr_pkg;

  function automatic int chanIdxW(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic inRange(input int code, input int base, input int num);
    return (code >= base) && (code < base + num);
  endfunction

  function automatic int laneLsb(input int idx, input int width);
    return idx * width;
  endfunction

  typedef struct packed {
    logic upd;     // UpdateDR addressed to this channel
    logic ack;     // consumer acknowledge
    logic clrOvr;  // capture addressed to this channel (clears overrun)
  } chanCtrl_t;

endpackage

// File: rtl/tdr_channel.sv
// tdr_channel: one parallel data register with its update handshake.
//   TCLK, TRESET : test clock, async active-high reset
//   ctrl         : update / ack / overrun-clear strobes from the bank decoder
//   din          : shared shift register contents
//   par          : parallel register, loaded on ctrl.upd
//   valid        : update pending for the consumer
//   overrun      : sticky, an update landed while the previous was unacked
module tdr_channel
  import tdr_pkg::*;
#(
  parameter int               WIDTH     = 17,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             TCLK,
  input  logic             TRESET,
  input  chanCtrl_t        ctrl,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] par,
  output logic             valid,
  output logic             overrun
);

  // An ack on the same edge as a new update retires the old one, so it
  // is not an overrun.
  logic ovrSet;
  assign ovrSet = ctrl.upd & valid & ~ctrl.ack;

  always_ff @(posedge TCLK or posedge TRESET) begin
    if (TRESET) begin
      par     <= RESET_VAL;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (ctrl.upd) begin
        par   <= din;
        valid <= 1'b1;
      end else if (ctrl.ack && valid) begin
        valid <= 1'b0;
      end
      // set has priority over clear
      if (ovrSet)           overrun <= 1'b1;
      else if (ctrl.clrOvr) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/tdr_bank.sv
// tdr_bank: bank of NUM_TDR JTAG data registers on one serial shift path.
//   TCLK, TRESET                  : test clock, async active-high reset
//   CaptureDR, ShiftDR, UpdateDR  : TAP state strobes
//   IR                            : current instruction code
//   SI / SO                       : serial in / out (LSB first)
//   Selected                      : IR falls in BASE_ADDR..BASE_ADDR+NUM_TDR-1
//   CaptureData / UpdateData      : per-channel words, lane i at [i*WIDTH +: WIDTH]
//   UpdateValid / UpdateAck       : per-channel update handshake
//   Overrun                       : per-channel sticky overrun flag
module tdr_bank
  import tdr_pkg::*;
#(
  parameter int               WIDTH     = 17,
  parameter int               NUM_TDR   = 4,
  parameter int               IR_W      = 8,
  parameter int               BASE_ADDR = 45,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       TCLK,
  input  logic                       TRESET,
  input  logic                       CaptureDR,
  input  logic                       ShiftDR,
  input  logic                       UpdateDR,
  input  logic [IR_W-1:0]            IR,
  input  logic                       SI,
  output logic                       SO,
  output logic                       Selected,
  input  logic [NUM_TDR*WIDTH-1:0]   CaptureData,
  output logic [NUM_TDR*WIDTH-1:0]   UpdateData,
  output logic [NUM_TDR-1:0]         UpdateValid,
  input  logic [NUM_TDR-1:0]         UpdateAck,
  output logic [NUM_TDR-1:0]         Overrun
);

  localparam int SEL_W = chanIdxW(NUM_TDR);

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] capWord;

  assign Selected = inRange(int'(IR), BASE_ADDR, NUM_TDR);
  // Only meaningful while Selected; out-of-window codes alias but are gated.
  assign sel      = SEL_W'(int'(IR) - BASE_ADDR);

  always_comb begin
    capWord = '0;
    for (int i = 0; i < NUM_TDR; i++)
      if (sel == SEL_W'(i)) capWord = CaptureData[laneLsb(i, WIDTH) +: WIDTH];
  end

  // Shared shift register; shift beats capture. Channels sample sr before
  // this edge's shift/capture.
  always_ff @(posedge TCLK or posedge TRESET) begin
    if (TRESET)                     sr <= '0;
    else if (Selected && ShiftDR)   sr <= {SI, sr[WIDTH-1:1]};
    else if (Selected && CaptureDR) sr <= capWord;
  end

  assign SO = Selected & sr[0];

  for (genvar g = 0; g < NUM_TDR; g++) begin : gChan
    logic      hit;
    chanCtrl_t ctrl;

    assign hit  = Selected && (sel == SEL_W'(g));
    assign ctrl = '{upd:    hit & UpdateDR,
                    ack:    UpdateAck[g],
                    clrOvr: hit & CaptureDR & ~ShiftDR};

    tdr_channel #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) uChan (
      .TCLK    (TCLK),
      .TRESET  (TRESET),
      .ctrl    (ctrl),
      .din     (sr),
      .par     (UpdateData[laneLsb(g, WIDTH) +: WIDTH]),
      .valid   (UpdateValid[g]),
      .overrun (Overrun[g])
    );
  end

endmodule

// File: tb/tb_tdr_bank.sv
module tb_tdr_bank;
  localparam int W = 17, N = 4, IRW = 8, BASE = 45;
  localparam logic [W-1:0] RV = 17'h1_5A5A;

  logic TCLK = 1'b0, TRESET = 1'b1;
  logic CaptureDR = 1'b0, ShiftDR = 1'b0, UpdateDR = 1'b0, SI = 1'b0;
  logic [IRW-1:0] IR = '0;
  logic SO, Selected;
  logic [N*W-1:0] CaptureData = '0;
  logic [N*W-1:0] UpdateData;
  logic [N-1:0] UpdateValid, Overrun;
  logic [N-1:0] UpdateAck = '0;

  int nChecks = 0, nFail = 0;

  // reference model state
  logic [W-1:0] mSr;
  logic [W-1:0] mPar [N];
  logic [N-1:0] mVal, mOvr;

  typedef struct packed { logic [1:0] ch; logic [W-1:0] data; } updExp_t;
  updExp_t updQ[$];
  logic    soQ[$];

  always #5 TCLK = ~TCLK;

  tdr_bank #(.WIDTH(W), .NUM_TDR(N), .IR_W(IRW), .BASE_ADDR(BASE), .RESET_VAL(RV)) dut (
    .TCLK(TCLK), .TRESET(TRESET), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
    .UpdateDR(UpdateDR), .IR(IR), .SI(SI), .SO(SO), .Selected(Selected),
    .CaptureData(CaptureData), .UpdateData(UpdateData), .UpdateValid(UpdateValid),
    .UpdateAck(UpdateAck), .Overrun(Overrun));

  task automatic modelReset();
    mSr = '0; mVal = '0; mOvr = '0;
    for (int i = 0; i < N; i++) mPar[i] = RV;
  endtask

  // Advance one clock; model computes next state from the inputs now applied
  // and queues every expected update. Returns 1 time unit after the edge.
  task automatic step();
    int s; logic hit, u; updExp_t e;
    logic [W-1:0] nSr; logic [N-1:0] nVal, nOvr; logic [W-1:0] nPar [N];
    s = int'(IR) - BASE;
    hit = (s >= 0) && (s < N);
    nSr = mSr; nVal = mVal; nOvr = mOvr; nPar = mPar;
    if (hit && ShiftDR)        nSr = {SI, mSr[W-1:1]};
    else if (hit && CaptureDR) nSr = CaptureData[s*W +: W];
    for (int i = 0; i < N; i++) begin
      u = hit && UpdateDR && (s == i);
      if (u) begin
        nPar[i] = mSr; nVal[i] = 1'b1;
        e.ch = 2'(i); e.data = mSr; updQ.push_back(e);
      end else if (UpdateAck[i] && mVal[i]) nVal[i] = 1'b0;
      if (u && mVal[i] && !UpdateAck[i]) nOvr[i] = 1'b1;
      else if (hit && CaptureDR && !ShiftDR && (s == i)) nOvr[i] = 1'b0;
    end
    @(posedge TCLK); #1;
    if (TRESET) modelReset();
    else begin mSr = nSr; mVal = nVal; mOvr = nOvr; mPar = nPar; end
  endtask

  task automatic shiftIn(input logic [W-1:0] v);
    ShiftDR = 1'b1;
    for (int k = 0; k < W; k++) begin SI = v[k]; step(); end
    ShiftDR = 1'b0; SI = 1'b0;
  endtask

  task automatic test_reset();
    updExp_t e;
    TRESET = 1'b1; step(); step();
    TRESET = 1'b0; #1;
    nChecks++; if (UpdateData !== {N{RV}}) begin nFail++; $display("FAIL rst_data: got %h want %h", UpdateData, {N{RV}}); end
    nChecks++; if (UpdateValid !== 4'b0) begin nFail++; $display("FAIL rst_valid: got %b want 0000", UpdateValid); end
    nChecks++; if (Overrun !== 4'b0) begin nFail++; $display("FAIL rst_ovr: got %b want 0000", Overrun); end
    nChecks++; if (SO !== 1'b0) begin nFail++; $display("FAIL rst_so: got %b want 0", SO); end
    // build up state, then reset asynchronously mid-shift with an update pending
    IR = 8'd46; CaptureData[W +: W] = 17'h0_00CF;
    CaptureDR = 1'b1; step(); CaptureDR = 1'b0;
    ShiftDR = 1'b1; SI = 1'b1; step(); step(); ShiftDR = 1'b0;
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL rst_pre_upd: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    nChecks++; if (UpdateValid !== 4'b0010) begin nFail++; $display("FAIL rst_pre_valid: got %b want 0010", UpdateValid); end
    ShiftDR = 1'b1; step();
    nChecks++; if (SO !== 1'b1) begin nFail++; $display("FAIL rst_pre_so: got %b want 1", SO); end
    #2 TRESET = 1'b1; #1;
    nChecks++; if (UpdateData !== {N{RV}}) begin nFail++; $display("FAIL arst_data: got %h want %h", UpdateData, {N{RV}}); end
    nChecks++; if (UpdateValid !== 4'b0 || Overrun !== 4'b0) begin nFail++; $display("FAIL arst_flags: got valid %b ovr %b want 0000", UpdateValid, Overrun); end
    nChecks++; if (SO !== 1'b0) begin nFail++; $display("FAIL arst_so: got %b want 0", SO); end
    ShiftDR = 1'b0; modelReset();
    #1 TRESET = 1'b0;
  endtask

  task automatic test_capture_shift();
    logic [W-1:0] cap; updExp_t e;
    cap = 17'h0_00CF;
    IR = 8'd46;
    CaptureData[0 +: W] = W'($urandom); CaptureData[2*W +: W] = W'($urandom);
    CaptureData[3*W +: W] = W'($urandom); CaptureData[W +: W] = cap;
    CaptureDR = 1'b1; step(); CaptureDR = 1'b0;
    nChecks++; if (Selected !== 1'b1) begin nFail++; $display("FAIL cap_sel: got %b want 1", Selected); end
    for (int k = 0; k < W; k++) soQ.push_back(cap[k]);
    for (int k = 0; k < W; k++) begin
      logic exp; exp = soQ.pop_front();
      nChecks++; if (SO !== exp) begin nFail++; $display("FAIL cap_so bit %0d: got %b want %b", k, SO, exp); end
      ShiftDR = 1'b1; SI = 1'b0; step();
    end
    ShiftDR = 1'b0;
    nChecks++; if (SO !== 1'b0) begin nFail++; $display("FAIL cap_so_end: got %b want 0", SO); end
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[W +: W] !== 17'h0) begin nFail++; $display("FAIL cap_sr_end: got %h want 00000", UpdateData[W +: W]); end
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL cap_sb: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    UpdateAck = 4'b0010; step(); UpdateAck = '0;
    nChecks++; if (UpdateValid !== mVal) begin nFail++; $display("FAIL cap_ack: got %b want %b", UpdateValid, mVal); end
  endtask

  task automatic test_update();
    updExp_t e; logic ok;
    IR = 8'd47; shiftIn(17'h1_2345);
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL upd_sb: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    nChecks++; if (UpdateData[2*W +: W] !== 17'h1_2345) begin nFail++; $display("FAIL upd_data: got %h want 12345", UpdateData[2*W +: W]); end
    nChecks++; if (UpdateValid !== 4'b0100) begin nFail++; $display("FAIL upd_valid: got %b want 0100", UpdateValid); end
    ok = (UpdateData[0 +: W] === RV) && (UpdateData[W +: W] === 17'h0) && (UpdateData[3*W +: W] === RV);
    nChecks++; if (!ok) begin nFail++; $display("FAIL upd_others: got %h", UpdateData); end
    UpdateAck = 4'b0100; step(); UpdateAck = '0;
    nChecks++; if (UpdateValid !== 4'b0000) begin nFail++; $display("FAIL upd_ack: got %b want 0000", UpdateValid); end
    UpdateAck = 4'b0100; step(); UpdateAck = '0;
    nChecks++; if (UpdateValid !== 4'b0000 || Overrun !== 4'b0000) begin nFail++; $display("FAIL upd_idle_ack: got valid %b ovr %b want 0000", UpdateValid, Overrun); end
  endtask

  task automatic test_overrun();
    updExp_t e;
    IR = 8'd45; shiftIn(17'h0_AAAA);
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL ovr_sb1: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    nChecks++; if (Overrun !== 4'b0000) begin nFail++; $display("FAIL ovr_first: got %b want 0000", Overrun); end
    shiftIn(17'h1_5555);
    // update samples sr from before the shift on the same edge
    UpdateDR = 1'b1; ShiftDR = 1'b1; SI = 1'b1; step(); UpdateDR = 1'b0; ShiftDR = 1'b0; SI = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL ovr_sb2: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    nChecks++; if (UpdateData[0 +: W] !== 17'h1_5555) begin nFail++; $display("FAIL ovr_data: got %h want 15555", UpdateData[0 +: W]); end
    nChecks++; if (Overrun !== 4'b0001) begin nFail++; $display("FAIL ovr_set: got %b want 0001", Overrun); end
    CaptureDR = 1'b1; step(); CaptureDR = 1'b0;
    nChecks++; if (Overrun !== 4'b0000) begin nFail++; $display("FAIL ovr_clr: got %b want 0000", Overrun); end
    nChecks++; if (UpdateValid !== 4'b0001) begin nFail++; $display("FAIL ovr_valid: got %b want 0001", UpdateValid); end
    UpdateAck = 4'b0001; step(); UpdateAck = '0;
    nChecks++; if (UpdateValid !== 4'b0000) begin nFail++; $display("FAIL ovr_ack: got %b want 0000", UpdateValid); end
  endtask

  task automatic test_collision();
    updExp_t e;
    IR = 8'd48; shiftIn(17'h0_1357);
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL col_sb1: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    shiftIn(17'h1_ACE1);
    UpdateDR = 1'b1; UpdateAck = 4'b1000; step(); UpdateDR = 1'b0; UpdateAck = '0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL col_sb2: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    nChecks++; if (UpdateData[3*W +: W] !== 17'h1_ACE1) begin nFail++; $display("FAIL col_data: got %h want 1ace1", UpdateData[3*W +: W]); end
    nChecks++; if (UpdateValid !== 4'b1000) begin nFail++; $display("FAIL col_valid: got %b want 1000", UpdateValid); end
    nChecks++; if (Overrun !== 4'b0000) begin nFail++; $display("FAIL col_ovr: got %b want 0000", Overrun); end
    UpdateAck = 4'b1000; step(); UpdateAck = '0;
    nChecks++; if (UpdateValid !== 4'b0000) begin nFail++; $display("FAIL col_ack: got %b want 0000", UpdateValid); end
  endtask

  task automatic test_out_of_range();
    logic [IRW-1:0] codes [2]; updExp_t e;
    codes[0] = 8'd44; codes[1] = 8'd49;
    IR = 8'd48; shiftIn(17'h0_0F0F);  // sr now differs from par[3]
    for (int c = 0; c < 2; c++) begin
      IR = codes[c]; CaptureDR = 1'b1; ShiftDR = 1'b1; UpdateDR = 1'b1; SI = 1'b1; #1;
      nChecks++; if (Selected !== 1'b0 || SO !== 1'b0) begin nFail++; $display("FAIL oor_sel ir=%0d: got sel %b so %b want 0 0", IR, Selected, SO); end
      step(); step();
      nChecks++; if (UpdateData[3*W +: W] !== 17'h1_ACE1 || UpdateValid !== 4'b0 || Overrun !== 4'b0) begin nFail++; $display("FAIL oor_state ir=%0d: got data %h valid %b ovr %b", IR, UpdateData, UpdateValid, Overrun); end
      CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0; SI = 1'b0;
    end
    IR = 8'd48; #1;
    nChecks++; if (Selected !== 1'b1 || SO !== 1'b1) begin nFail++; $display("FAIL oor_back: got sel %b so %b want 1 1", Selected, SO); end
    UpdateDR = 1'b1; step(); UpdateDR = 1'b0;
    e = updQ.pop_front();
    nChecks++; if (UpdateData[3*W +: W] !== 17'h0_0F0F) begin nFail++; $display("FAIL oor_sr: got %h want 00f0f", UpdateData[3*W +: W]); end
    nChecks++; if (UpdateData[e.ch*W +: W] !== e.data) begin nFail++; $display("FAIL oor_sb: got %h want %h", UpdateData[e.ch*W +: W], e.data); end
    UpdateAck = 4'b1000; step(); UpdateAck = '0;
  endtask

  initial begin
    test_reset();
    test_capture_shift();
    test_update();
    test_overrun();
    test_collision();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
